// File: rtl/sm4_keyexp_if.sv
// Request/read bus of the SM4 key-expansion engine.
// The master side starts an expansion and reads round keys; the slave side is the engine.
interface sm4_keyexp_if #(
  parameter int IDXW = 5
) ();
  logic            start_i;
  logic [127:0]    mk_i;
  logic            busy_o;
  logic            done_o;
  logic            rk_valid_o;
  logic [IDXW-1:0] rd_idx_i;
  logic            rd_dec_i;
  logic [31:0]     rk_o;

  modport master (
    output start_i, mk_i, rd_idx_i, rd_dec_i,
    input  busy_o, done_o, rk_valid_o, rk_o
  );

  modport slave (
    input  start_i, mk_i, rd_idx_i, rd_dec_i,
    output busy_o, done_o, rk_valid_o, rk_o
  );
endinterface

// File: rtl/sm4_keyexp.sv
// Iterative SM4 key expansion: 32 round keys into a register file, one round per cycle.
// Define SM4_KEYEXP_2RND_EN to compute two rounds per cycle (16-cycle expansion).
module sm4_keyexp #(
  parameter int NRND = 32
) (
  input  logic              clk,
  input  logic              rst,
  sm4_keyexp_if.slave       bus
);
  localparam int IDXW = $clog2(NRND);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NRND - 1);
  localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);
  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Round constant: byte j of CK[i] is (4i+j)*7 mod 256, MSB first.
  function automatic logic [31:0] ck_of(input logic [IDXW-1:0] i);
    logic [7:0] base;
    base = {1'b0, i, 2'b00};
    return {8'((base + 8'd0) * 8'd7), 8'((base + 8'd1) * 8'd7),
            8'((base + 8'd2) * 8'd7), 8'((base + 8'd3) * 8'd7)};
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] a);
    logic [31:0] b;
    b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        cnt_q, cnt_d;
  logic [3:0][31:0]       k_q, k_d;
  logic [NRND-1:0][31:0]  rk_q, rk_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;

  logic [31:0]            t0;
`ifdef SM4_KEYEXP_2RND_EN
  logic [31:0]            t1;
`endif
  logic [IDXW-1:0]        rd_sel;

  // k_q[0] is K0 (oldest word), k_q[3] is K3 (newest word).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    t0      = k_q[0] ^ t_prime(k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_of(cnt_q));
`ifdef SM4_KEYEXP_2RND_EN
    t1      = k_q[1] ^ t_prime(k_q[2] ^ k_q[3] ^ t0 ^ ck_of(cnt_q + ONE_IDX));
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          k_d     = {bus.mk_i[31:0], bus.mk_i[63:32], bus.mk_i[95:64], bus.mk_i[127:96]}
                    ^ {FK[31:0], FK[63:32], FK[95:64], FK[127:96]};
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef SM4_KEYEXP_2RND_EN
        rk_d[cnt_q]           = t0;
        rk_d[cnt_q + ONE_IDX] = t1;
        k_d   = {t1, t0, k_q[3], k_q[2]};
        cnt_d = cnt_q + IDXW'(2);
        if (cnt_q == LAST_IDX - ONE_IDX) begin
`else
        rk_d[cnt_q] = t0;
        k_d   = {t0, k_q[3], k_q[2], k_q[1]};
        cnt_d = cnt_q + ONE_IDX;
        if (cnt_q == LAST_IDX) begin
`endif
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset also clears the key file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rk_q    <= rk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Decrypt order simply mirrors the index.
  assign rd_sel         = bus.rd_dec_i ? (LAST_IDX - bus.rd_idx_i) : bus.rd_idx_i;
  assign bus.rk_o       = rk_q[rd_sel];
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.rk_valid_o = valid_q;

endmodule
